// File: rtl/measurement_sequencer_pkg.sv
// Shared types and constants for the measurement sequencer: FSM states,
// the converter operand limit, lamp-test pattern and decimal-point width.
package measurement_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCALE,
        S_CONVERT,
        S_WAIT,
        S_LATCH,
        S_HOLD
    } state_t;

    localparam logic [31:0] SCALE_LIMIT = 32'h0100_0000;
    localparam logic [31:0] LAMP_TEST   = 32'h8888_8888;
    localparam int          DP_W        = 8;

endpackage

// File: rtl/measurement_sequencer_divide_by_ten_seq.sv
// Sequential restoring divide-by-ten: one load clock, then one quotient bit
// per clock for 32 clocks; the remainder is discarded.
module divide_by_ten_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] dividend,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient
);

    logic [31:0] shreg;
    logic [3:0]  rem;
    logic [5:0]  count;
    logic        active;
    logic [4:0]  trial;
    logic [3:0]  diff;

    // Dividend bits leave the top of shreg while quotient bits enter the bottom.
    assign trial = {rem, shreg[31]};
    assign diff  = trial[3:0] - 4'd10;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg  <= '0;
            rem    <= '0;
            count  <= '0;
            active <= 1'b0;
        end else if (load) begin
            shreg  <= dividend;
            rem    <= '0;
            count  <= '0;
            active <= 1'b1;
        end else if (active && count != 6'd32) begin
            if (trial >= 5'd10) begin
                rem   <= diff;
                shreg <= {shreg[30:0], 1'b1};
            end else begin
                rem   <= trial[3:0];
                shreg <= {shreg[30:0], 1'b0};
            end
            count <= count + 6'd1;
        end else if (done) begin
            active <= 1'b0;
        end
    end

    assign busy     = active;
    assign done     = active && (count == 6'd32);
    assign quotient = shreg;

endmodule

// File: rtl/measurement_sequencer.sv
// Takes frequency measurements, scales them by powers of ten into the 24-bit
// converter range, runs the BCD converter and paces display updates.
module measurement_sequencer
    import measurement_sequencer_pkg::*;
#(
    parameter int              DISPLAY_HOLD_CYCLES    = 1048576,
    parameter int              CONVERT_TIMEOUT_CYCLES = 1024,
    parameter logic [DP_W-1:0] DP_BASE                = 8'b01000000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            measurement_valid,
    input  logic [31:0]     measurement,
    output logic            bcd_start,
    output logic [23:0]     hex_to_convert,
    input  logic            bcd_done,
    input  logic [31:0]     bcd_in,
    output logic [31:0]     display_data,
    output logic [DP_W-1:0] dp,
    output logic            update_strobe,
    output logic            convert_error,
    output logic            busy,
    output state_t          debug_state
);

    localparam int TW = (CONVERT_TIMEOUT_CYCLES > 1) ? $clog2(CONVERT_TIMEOUT_CYCLES) : 1;
    localparam int HW = (DISPLAY_HOLD_CYCLES > 1) ? $clog2(DISPLAY_HOLD_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST   = TW'(CONVERT_TIMEOUT_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(DISPLAY_HOLD_CYCLES - 1);

    state_t        state, state_next;
    logic [1:0]    rst_sync;
    logic          rst_i;
    logic [31:0]   pending_val;
    logic          pending_flag;
    logic [31:0]   working;
    logic [1:0]    k;
    logic [TW-1:0] tcount;
    logic [HW-1:0] hcount;
    logic [31:0]   bcd_q;
    logic [31:0]   cur;
    logic          div_load, div_busy, div_done;
    logic [31:0]   div_q;

    // Assert immediately, release two clocks after reset drops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) rst_sync <= 2'b11;
        else       rst_sync <= {rst_sync[0], 1'b0};
    end
    assign rst_i = rst_sync[1];

    divide_by_ten_seq u_div (
        .clock    (clock),
        .reset    (rst_i),
        .load     (div_load),
        .dividend (cur),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q)
    );

    // Use the fresh quotient in its done cycle so each divide costs exactly 33 clocks.
    assign cur = div_done ? div_q : working;

    always_comb begin
        state_next = state;
        div_load   = 1'b0;
        case (state)
            S_IDLE:    if (pending_flag) state_next = S_SCALE;
            S_SCALE: begin
                if (!div_busy || div_done) begin
                    if (cur >= SCALE_LIMIT) div_load   = 1'b1;
                    else                    state_next = S_CONVERT;
                end
            end
            S_CONVERT: state_next = S_WAIT;
            S_WAIT: begin
                if (bcd_done)                state_next = S_LATCH;
                else if (tcount == TO_LAST)  state_next = S_HOLD;
            end
            S_LATCH:   state_next = S_HOLD;
            S_HOLD:    if (hcount == HOLD_LAST) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge rst_i) begin
        if (rst_i) begin
            state          <= S_IDLE;
            pending_val    <= '0;
            pending_flag   <= 1'b0;
            working        <= '0;
            k              <= '0;
            tcount         <= '0;
            hcount         <= '0;
            bcd_q          <= '0;
            bcd_start      <= 1'b0;
            hex_to_convert <= '0;
            display_data   <= LAMP_TEST;
            dp             <= '1;
            update_strobe  <= 1'b0;
            convert_error  <= 1'b0;
        end else begin
            state         <= state_next;
            bcd_start     <= 1'b0;
            update_strobe <= 1'b0;

            if (measurement_valid) pending_val <= measurement;
            // A pulse arriving in the consume cycle keeps the flag set.
            pending_flag <= measurement_valid | (pending_flag & (state != S_IDLE));

            if (state == S_IDLE && pending_flag) begin
                working <= pending_val;
                k       <= '0;
            end
            if (div_done) begin
                working <= div_q;
                k       <= k + 2'd1;
            end

            if (state == S_SCALE && state_next == S_CONVERT) begin
                hex_to_convert <= cur[23:0];
                bcd_start      <= 1'b1;
            end

            if (state == S_CONVERT) tcount <= '0;
            else if (state == S_WAIT && tcount != TO_LAST) tcount <= tcount + TW'(1);

            if (state == S_WAIT && bcd_done) bcd_q <= bcd_in;
            if (state == S_WAIT && !bcd_done && tcount == TO_LAST) convert_error <= 1'b1;

            if (state == S_LATCH) begin
                display_data  <= bcd_q;
                dp            <= DP_BASE >> k;
                update_strobe <= 1'b1;
                convert_error <= 1'b0;
            end

            if (state != S_HOLD && state_next == S_HOLD) hcount <= '0;
            else if (state == S_HOLD && hcount != HOLD_LAST) hcount <= hcount + HW'(1);
        end
    end

    assign busy        = (state != S_IDLE);
    assign debug_state = state;

endmodule
